// File: rtl/regfile_sequencer.sv
// rtl/regfile_sequencer.sv - multi-cycle register file control sequencer
// Sequences decode, register read, ALU/memory wait and writeback for one instruction at a time.
module regfile_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  output logic             instr_ready,
  output logic [4:0]       rf_addr1,
  output logic [4:0]       rf_addr2,
  output logic [4:0]       rf_addr3,
  output logic [3:0]       rf_en,
  output logic             rf_enw,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic             mem_ack,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] retired
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    READ,
    EXEC,
    WAIT,
    WB
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [20:0]   instr_q;
  logic [3:0]    cls_q;
  logic [TW-1:0] cnt;
  logic [3:0]    dec_cls;
  logic [4:0]    dec_dest;
  logic          done_in;
  logic          timed_out;
  logic          unused_bits;

  // Only opcode and register fields are kept; the immediate/funct bits are not needed here.
  assign unused_bits = ^instr[10:0];

  always_comb begin
    dec_cls  = 4'b0000;
    dec_dest = 5'd0;
    casez (instr_q[20:15])
      6'b000000: begin dec_cls = 4'b0001; dec_dest = instr_q[4:0];  end
      6'b001???: begin dec_cls = 4'b0010; dec_dest = instr_q[9:5];  end
      6'b100011: begin dec_cls = 4'b0100; dec_dest = instr_q[9:5];  end
      6'b101011: begin dec_cls = 4'b1000; dec_dest = 5'd0;          end
      default:   begin dec_cls = 4'b0000; dec_dest = 5'd0;          end
    endcase
  end

  // Memory classes complete on mem_ack, ALU classes on alu_done; the other input is ignored.
  assign done_in   = (cls_q[2] | cls_q[3]) ? mem_ack : alu_done;
  assign timed_out = (cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    busy        = 1'b1;
    alu_start   = 1'b0;
    rf_enw      = 1'b0;
    rf_en       = 4'b0000;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
        if (instr_valid) state_nx = DECODE;
      end
      DECODE: state_nx = (dec_cls == 4'b0000) ? IDLE : READ;
      READ: begin
        rf_en    = cls_q;
        state_nx = EXEC;
      end
      EXEC: begin
        rf_en     = cls_q;
        alu_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        rf_en = cls_q;
        if (done_in)        state_nx = cls_q[3] ? IDLE : WB;
        else if (timed_out) state_nx = IDLE;
      end
      WB: begin
        rf_en    = cls_q;
        rf_enw   = (rf_addr3 != 5'd0);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= '0;
      cls_q    <= 4'b0000;
      rf_addr1 <= 5'd0;
      rf_addr2 <= 5'd0;
      rf_addr3 <= 5'd0;
      cnt      <= '0;
      err      <= 1'b0;
      retired  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (instr_valid) begin
            instr_q <= instr[31:11];
            err     <= 1'b0;
          end
        end
        DECODE: begin
          cls_q    <= dec_cls;
          rf_addr1 <= instr_q[14:10];
          rf_addr2 <= instr_q[9:5];
          rf_addr3 <= dec_dest;
          if (dec_cls == 4'b0000) err <= 1'b1;
        end
        EXEC: cnt <= '0;
        WAIT: begin
          if (done_in) begin
            if (cls_q[3]) retired <= retired + 1'b1;
          end else if (timed_out) begin
            err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB: retired <= retired + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Multi-cycle control FSM that sequences the 32×32 register file for one instruction at a time. It accepts a 32-bit instruction over a valid/ready handshake, decodes the register fields, and drives the register file's read addresses, write address, 4-bit enable and write-enable. It starts the ALU or waits on memory, then commits writeback. It sits between instruction fetch and the register file/ALU datapath, and it is the only driver of the register file control inputs.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of WAIT cycles before the instruction is aborted (≥1).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- instr_valid  in  1  instruction available.
- instr  in  32  instruction word: [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- rf_addr1  out  5  read address 1 (rs).
- rf_addr2  out  5  read address 2 (rt).
- rf_addr3  out  5  write address.
- rf_en  out  4  instruction-class enable: 0001 R-type, 0010 I-type, 0100 load, 1000 store, 0000 inactive.
- rf_enw  out  1  write enable; one-cycle pulse in WB.
- alu_start  out  1  one-cycle pulse in EXEC.
- alu_done  in  1  ALU result ready (R/I-type).
- mem_ack  in  1  memory complete (load/store).
- busy  out  1  high in every state except IDLE.
- err  out  1  sticky error flag; cleared on the next accepted instruction.
- retired  out  CNT_W  count of instructions completed without error; wraps.

## Operation
- States: IDLE, DECODE, READ, EXEC, WAIT, WB.
- IDLE: instr_ready=1. On instr_valid=1, latch instr, clear err, go to DECODE. Otherwise stay in IDLE.
- DECODE classifies the opcode:
  - 000000: R-type, dest=rd.
  - 001xxx: I-type, dest=rt.
  - 100011: load, dest=rt.
  - 101011: store, no destination.
  - Any other opcode: set err=1, return to IDLE. No rf_en, no alu_start, retired unchanged.
- DECODE loads rf_addr1=rs, rf_addr2=rt, rf_addr3=dest (0 for store). Addresses hold until the next accept.
- READ: rf_en = class code; the register file is read this cycle.
- EXEC: alu_start=1 for every class (loads and stores use the ALU for address computation). Go to WAIT.
- WAIT:
  - R/I-type: sample alu_done only. Load/store: sample mem_ack only.
  - When the sampled input is high: go to WB (R/I/load) or straight to IDLE (store, retired+1).
  - Timeout counter starts at 0 on WAIT entry and increments each WAIT cycle. When it reaches TIMEOUT with no completion, set err=1 and go to IDLE. No writeback, retired unchanged.
  - Completion in the same cycle the counter reaches TIMEOUT: completion wins.
- WB: rf_enw=1 unless dest==0 (r0 write suppressed, rf_enw=0). retired+1 either way. Go to IDLE.
- rf_en holds its class code from READ through WB, and is 0000 in IDLE and DECODE.
- alu_done and mem_ack are ignored outside WAIT.
- rst in any state: synchronously return to IDLE and drop all pulses the following cycle. Any in-flight instruction is discarded with no write.

## Timing
- Reset values: instr_ready=1, rf_addr1/2/3=0, rf_en=0000, rf_enw=0, alu_start=0, busy=0, err=0, retired=0.
- All outputs are registered or decoded from the state register only; no combinational path from any input to any output.
- Cycle schedule (accept at edge T):
  - T+1: DECODE.
  - T+2: READ.
  - T+3: EXEC, alu_start high.
  - T+4: first WAIT cycle.
- Completion sampled at T+4: WB at T+5 (rf_enw high, retired updates at the end of T+5), IDLE with instr_ready=1 at T+6.
- Minimum issue interval is 6 cycles (5 for store).
- Timeout abort: err high and IDLE in the cycle after the TIMEOUT-th WAIT cycle.
- retired wraps from 2^CNT_W−1 to 0.

## Test plan
- R-type: instr=0x00430820 (rs=2, rt=3, rd=1), alu_done high at T+4 → rf_addr1=2, rf_addr2=3, rf_addr3=1, rf_en=0001 at T+2..T+5, alu_start at T+3 only, rf_enw at T+5 only, retired=1, instr_ready at T+6.
- Load: opcode 100011, rt=5, mem_ack after 3 WAIT cycles → rf_en=0100, rf_addr3=5, single rf_enw pulse, alu_done pulses during WAIT ignored.
- Write to r0: R-type with rd=0 → no rf_enw pulse, retired still increments.
- Timeout: TIMEOUT=4, no alu_done → err=1 after 4 WAIT cycles, no rf_enw, retired unchanged. Next valid instruction clears err on accept. Completion arriving exactly on the 4th WAIT cycle → normal WB, err=0.
- Illegal opcode 111111 → err=1 at T+2, back to IDLE, alu_start never pulses.
- rst asserted in WAIT and in WB → IDLE next cycle, all outputs at reset values, no rf_enw pulse afterwards. retired wrap check with CNT_W=2: 4 stores → retired=0.
